// File: rtl/arb_pkg.sv
// Shared types and constants for the registered round-robin/fixed-priority arbiter.
// No logic of its own; latency and backpressure are defined by the arbiter top.
// Imported by rr_find_first and rr_priority_arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam bit ARB_MODE_FIXED = 1'b0;
    localparam bit ARB_MODE_RR    = 1'b1;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_find_first.sv
// Rotated find-first: first set bit of req scanning upward from ptr, wrapping at N-1.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is consumed.
module rr_find_first
    import arb_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    // One spare bit so ptr + k (< 2N) never overflows before the wrap compare.
    logic [IDX_W:0] pos;

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        pos    = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(N)) begin
                pos = pos - (IDX_W+1)'(N);
            end
            if (!found && req[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[IDX_W-1:0];
            end
        end
        if (found) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered N-way arbiter, fixed-priority (bit 0 highest) or round-robin, valid/ready grant port.
// First grant one cycle after req is seen in IDLE; back-to-back grants with no bubble.
// Grant held bit-stable while grant_ready is low; req changes ignored while a grant is pending.
module rr_priority_arbiter
    import arb_pkg::*;
#(
    parameter int N     = 8,
    parameter bit RR    = ARB_MODE_RR,
    parameter int IDX_W = idx_width(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N-1:0]     grant_onehot,
    input  logic             grant_ready
);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic             load;

    logic             ff_found;
    logic [IDX_W-1:0] ff_idx;
    logic [N-1:0]     ff_onehot;

    // The scan uses the post-accept pointer so the next winner sees the rotation immediately.
    rr_find_first #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_find_first (
        .req    (req),
        .ptr    (ptr_nxt),
        .found  (ff_found),
        .idx    (ff_idx),
        .onehot (ff_onehot)
    );

    assign grant_valid = (state == GRANT);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (ff_found) begin
                    load      = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (grant_ready) begin
                    if (RR != ARB_MODE_FIXED) begin
                        ptr_nxt = (grant_idx == IDX_W'(N-1)) ? '0 : grant_idx + 1'b1;
                    end
                    if (ff_found) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr          <= '0;
            grant_idx    <= '0;
            grant_onehot <= '0;
        end else begin
            ptr <= ptr_nxt;
            if (load) begin
                grant_idx    <= ff_idx;
                grant_onehot <= ff_onehot;
            end else if (state_nxt == IDLE) begin
                // grant_idx keeps its last value in IDLE; only the one-hot clears.
                grant_onehot <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Three arbiters (N=8 RR, N=8 fixed, N=5 RR) driven together and compared every cycle
// against a queue-free behavioural model plus directed constant checks.
module tb_rr_priority_arbiter;

    logic       clk;
    logic       reset;
    logic [7:0] req_a, req_b;
    logic [4:0] req_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic       vld_a, vld_b, vld_c;
    logic [2:0] idx_a, idx_b, idx_c;
    logic [7:0] oh_a, oh_b;
    logic [4:0] oh_c;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    int m_ptr[3];
    int m_idx[3];
    bit m_vld[3];

    rr_priority_arbiter #(.N(8), .RR(1'b1)) u_a (
        .clk(clk), .reset(reset), .req(req_a), .grant_valid(vld_a),
        .grant_idx(idx_a), .grant_onehot(oh_a), .grant_ready(rdy_a)
    );
    rr_priority_arbiter #(.N(8), .RR(1'b0)) u_b (
        .clk(clk), .reset(reset), .req(req_b), .grant_valid(vld_b),
        .grant_idx(idx_b), .grant_onehot(oh_b), .grant_ready(rdy_b)
    );
    rr_priority_arbiter #(.N(5), .RR(1'b1)) u_c (
        .clk(clk), .reset(reset), .req(req_c), .grant_valid(vld_c),
        .grant_idx(idx_c), .grant_onehot(oh_c), .grant_ready(rdy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int n_of(input int i);
        return (i == 2) ? 5 : 8;
    endfunction

    function automatic bit rr_of(input int i);
        return (i != 1);
    endfunction

    function automatic logic [63:0] req_of(input int i);
        case (i)
            0:       return {56'd0, req_a};
            1:       return {56'd0, req_b};
            default: return {59'd0, req_c};
        endcase
    endfunction

    function automatic bit rdy_of(input int i);
        case (i)
            0:       return rdy_a;
            1:       return rdy_b;
            default: return rdy_c;
        endcase
    endfunction

    // First requester at or after p, in circular order of n.
    function automatic int pick(input logic [63:0] r, input int n, input int p);
        for (int k = 0; k < n; k++) begin
            if (r[(p + k) % n]) return (p + k) % n;
        end
        return 0;
    endfunction

    task automatic model_step(input int i);
        logic [63:0] r;
        r = req_of(i);
        if (reset) begin
            m_vld[i] = 1'b0;
            m_idx[i] = 0;
            m_ptr[i] = 0;
        end else if (!m_vld[i]) begin
            if (r != 0) begin
                m_idx[i] = pick(r, n_of(i), m_ptr[i]);
                m_vld[i] = 1'b1;
            end
        end else if (rdy_of(i)) begin
            if (rr_of(i)) m_ptr[i] = (m_idx[i] + 1) % n_of(i);
            if (r != 0) m_idx[i] = pick(r, n_of(i), m_ptr[i]);
            else        m_vld[i] = 1'b0;
        end
    endtask

    task automatic check_inst(input int i);
        logic        v;
        logic [63:0] ix, oh, exp_oh;
        case (i)
            0:       begin v = vld_a; ix = {61'd0, idx_a}; oh = {56'd0, oh_a}; end
            1:       begin v = vld_b; ix = {61'd0, idx_b}; oh = {56'd0, oh_b}; end
            default: begin v = vld_c; ix = {61'd0, idx_c}; oh = {59'd0, oh_c}; end
        endcase
        exp_oh = m_vld[i] ? (64'd1 << m_idx[i]) : 64'd0;
        chk($sformatf("inst%0d valid", i),  {63'd0, v}, {63'd0, m_vld[i]});
        chk($sformatf("inst%0d idx", i),    ix, 64'(m_idx[i]));
        chk($sformatf("inst%0d onehot", i), oh, exp_oh);
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) check_inst(i);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_ptr[i] = 0; m_idx[i] = 0; m_vld[i] = 1'b0;
        end
        reset = 1'b1;
        req_a = 8'hFF; req_b = 8'hFF; req_c = 5'h1F;
        rdy_a = 1'b0;  rdy_b = 1'b0;  rdy_c = 1'b0;
        #1;

        // Reset held two cycles with every request up.
        step();
        step();
        chk("rst valid",  {63'd0, vld_a}, 64'd0);
        chk("rst idx",    {61'd0, idx_a}, 64'd0);
        chk("rst onehot", {56'd0, oh_a},  64'd0);

        reset = 1'b0;
        step();
        chk("first grant valid", {63'd0, vld_a}, 64'd1);
        chk("first grant idx",   {61'd0, idx_a}, 64'd0);

        // Round-robin rotation 0..7,0 with no bubbles.
        rdy_a = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("rot%0d idx", k), {61'd0, idx_a}, 64'(k % 8));
            chk($sformatf("rot%0d valid", k), {63'd0, vld_a}, 64'd1);
        end

        // Fixed priority: 8'b1010_0000 always yields 5, then IDLE on no request.
        req_b = 8'b1010_0000; rdy_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("fixed%0d idx", k), {61'd0, idx_b}, 64'd5);
        end
        req_b = 8'h00;
        step();
        chk("fixed idle valid",  {63'd0, vld_b}, 64'd0);
        chk("fixed idle onehot", {56'd0, oh_b},  64'd0);

        // Backpressure: grant 2 held while req changes underneath.
        reset = 1'b1;
        step();
        reset = 1'b0; req_a = 8'h0C; rdy_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) req_a = 8'h01;
            step();
            chk($sformatf("hold%0d idx", k),    {61'd0, idx_a}, 64'd2);
            chk($sformatf("hold%0d onehot", k), {56'd0, oh_a},  64'h04);
        end
        rdy_a = 1'b1;
        step();
        chk("post-hold idx", {61'd0, idx_a}, 64'd0);

        // Non-power-of-two wrap on N=5: 0,4,0,4.
        reset = 1'b1;
        step();
        reset = 1'b0; req_c = 5'b10001; rdy_c = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("wrap5_%0d idx", k), {61'd0, idx_c}, (k % 2 == 0) ? 64'd0 : 64'd4);
        end

        // Reset while a grant is pending under backpressure.
        req_a = 8'hFF; rdy_a = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        chk("midrst valid", {63'd0, vld_a}, 64'd0);
        reset = 1'b0;
        step();
        chk("midrst regrant idx", {61'd0, idx_a}, 64'd0);
        rdy_a = 1'b1;
        step();
        chk("midrst ptr restart", {61'd0, idx_a}, 64'd1);

        // Ready high in IDLE has no effect.
        req_a = 8'h00; req_b = 8'h00; req_c = 5'h00;
        rdy_a = 1'b1;  rdy_b = 1'b1;  rdy_c = 1'b1;
        for (int k = 0; k < 3; k++) step();

        // Random traffic against the model.
        for (int k = 0; k < 800; k++) begin
            logic [7:0] r;
            reset = ($urandom_range(0, 63) == 0);
            r = 8'($urandom);
            if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
            if ($urandom_range(0, 7) == 0) r = 8'h00;
            req_a = r;
            req_b = 8'($urandom);
            req_c = 5'($urandom) & 5'($urandom);
            rdy_a = ($urandom_range(0, 3) != 0);
            rdy_b = ($urandom_range(0, 1) != 0);
            rdy_c = ($urandom_range(0, 4) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
